// File: rtl/reorient_tri_pipe.sv
// reorient_tri_pipe
//   Pipelined triangle reorientation. Finds the longest edge of a triangle by squared XY
//   length, rotates the vertex order so that edge becomes PQ, and reports which original
//   edge it was (1=PQ, 2=QR, 3=RP) together with its squared length.
//
//   Optional feature macro: REORIENT_WINDING_EN
//     When defined, an extra stage S4 swaps output P and Q if the rotated triangle has
//     negative winding and raises flipped. When undefined, flipped is tied 0.
//
// Ports
//   clk       clock, all state on rising edge
//   rst       asynchronous active-high reset
//   in_valid  input triangle valid
//   in_ready  block can accept input (pipeline enable)
//   tri_in    {p.x,p.y,p.z,q.x,q.y,q.z,r.x,r.y,r.z}, p.x in MSBs, two's complement
//   out_valid output triangle valid
//   out_ready downstream accepts output
//   tri_out   reoriented triangle, same packing
//   edge_sel  original longest edge
//   len_sq    unsigned squared XY length of the selected edge
//   flipped   winding swap applied
module reorient_tri_pipe #(
    parameter int unsigned COORD_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [9*COORD_W-1:0] tri_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [9*COORD_W-1:0] tri_out,
    output logic [1:0]           edge_sel,
    output logic [2*COORD_W+2:0] len_sq,
    output logic                 flipped
);

    localparam int unsigned W  = COORD_W;
    localparam int unsigned TW = 9 * W;
    localparam int unsigned VW = 3 * W;
    localparam int unsigned DW = W + 1;
    localparam int unsigned SW = 2 * W + 2;
    localparam int unsigned LW = 2 * W + 3;

    // Bit offsets of the XY coordinates inside a packed triangle
    localparam int unsigned PX = 8 * W;
    localparam int unsigned PY = 7 * W;
    localparam int unsigned QX = 5 * W;
    localparam int unsigned QY = 4 * W;
    localparam int unsigned RX = 2 * W;
    localparam int unsigned RY = 1 * W;

    // Sign-extended difference a-b, one bit wider than the operands so it never overflows
    function automatic logic [DW-1:0] sub_ext(input logic [W-1:0] a, input logic [W-1:0] b);
        sub_ext = {a[W-1], a} - {b[W-1], b};
    endfunction

    // Square of a signed delta; the low SW bits of the product are exact since d^2 < 2^SW
    function automatic logic [SW-1:0] square(input logic [DW-1:0] d);
        logic [SW-1:0] e;
        e      = {{(SW - DW){d[DW-1]}}, d};
        square = e * e;
    endfunction

    logic pipe_en;

    // S1: triangle plus XY deltas (index 0=PQ, 1=QR, 2=RP)
    logic          s1_vld_q;
    logic [TW-1:0] s1_tri_q;
    logic [DW-1:0] s1_dx_q [3];
    logic [DW-1:0] s1_dy_q [3];
    logic [DW-1:0] s1_dx_d [3];
    logic [DW-1:0] s1_dy_d [3];

    // S2: triangle plus squared lengths
    logic          s2_vld_q;
    logic [TW-1:0] s2_tri_q;
    logic [LW-1:0] s2_d_q [3];
    logic [LW-1:0] s2_d_d [3];

    // S3: rotated triangle, selection and length
    logic          s3_vld_q;
    logic [TW-1:0] s3_tri_q;
    logic [1:0]    s3_sel_q;
    logic [LW-1:0] s3_len_q;
    logic [TW-1:0] s3_tri_d;
    logic [1:0]    s3_sel_d;
    logic [LW-1:0] s3_len_d;

    always_comb begin
        s1_dx_d[0] = sub_ext(tri_in[PX +: W], tri_in[QX +: W]);
        s1_dy_d[0] = sub_ext(tri_in[PY +: W], tri_in[QY +: W]);
        s1_dx_d[1] = sub_ext(tri_in[QX +: W], tri_in[RX +: W]);
        s1_dy_d[1] = sub_ext(tri_in[QY +: W], tri_in[RY +: W]);
        s1_dx_d[2] = sub_ext(tri_in[RX +: W], tri_in[PX +: W]);
        s1_dy_d[2] = sub_ext(tri_in[RY +: W], tri_in[PY +: W]);
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            s2_d_d[i] = {1'b0, square(s1_dx_q[i])} + {1'b0, square(s1_dy_q[i])};
        end
    end

    always_comb begin
        // Strict compares: all-equal resolves to RP, d1==d2>d3 resolves to QR
        if (s2_d_q[0] > s2_d_q[1]) begin
            s3_sel_d = (s2_d_q[0] > s2_d_q[2]) ? 2'd1 : 2'd3;
        end else begin
            s3_sel_d = (s2_d_q[1] > s2_d_q[2]) ? 2'd2 : 2'd3;
        end
        s3_tri_d = s2_tri_q;
        s3_len_d = s2_d_q[2];
        case (s3_sel_d)
            2'd1: begin
                s3_tri_d = s2_tri_q;
                s3_len_d = s2_d_q[0];
            end
            2'd2: begin
                s3_tri_d = {s2_tri_q[VW +: VW], s2_tri_q[0 +: VW], s2_tri_q[2*VW +: VW]};
                s3_len_d = s2_d_q[1];
            end
            default: begin
                s3_tri_d = {s2_tri_q[0 +: VW], s2_tri_q[2*VW +: VW], s2_tri_q[VW +: VW]};
                s3_len_d = s2_d_q[2];
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            s1_tri_q <= '0;
            for (int i = 0; i < 3; i++) begin
                s1_dx_q[i] <= '0;
                s1_dy_q[i] <= '0;
                s2_d_q[i]  <= '0;
            end
            s2_vld_q <= 1'b0;
            s2_tri_q <= '0;
            s3_vld_q <= 1'b0;
            s3_tri_q <= '0;
            s3_sel_q <= '0;
            s3_len_q <= '0;
        end else if (pipe_en) begin
            s1_vld_q <= in_valid;
            s1_tri_q <= tri_in;
            for (int i = 0; i < 3; i++) begin
                s1_dx_q[i] <= s1_dx_d[i];
                s1_dy_q[i] <= s1_dy_d[i];
                s2_d_q[i]  <= s2_d_d[i];
            end
            s2_vld_q <= s1_vld_q;
            s2_tri_q <= s1_tri_q;
            s3_vld_q <= s2_vld_q;
            s3_tri_q <= s3_tri_d;
            s3_sel_q <= s3_sel_d;
            s3_len_q <= s3_len_d;
        end
    end

`ifdef REORIENT_WINDING_EN
    localparam int unsigned CW = 2 * W + 4;

    function automatic logic [CW-1:0] ext_c(input logic [DW-1:0] d);
        ext_c = {{(CW - DW){d[DW-1]}}, d};
    endfunction

    logic          s4_vld_q;
    logic [TW-1:0] s4_tri_q;
    logic [1:0]    s4_sel_q;
    logic [LW-1:0] s4_len_q;
    logic          s4_flip_q;
    logic [CW-1:0] s4_cross;
    logic [TW-1:0] s4_tri_d;
    logic          s4_flip_d;

    always_comb begin
        // Cross product of the rotated triangle; its sign bit marks clockwise winding
        s4_cross = ext_c(sub_ext(s3_tri_q[QX +: W], s3_tri_q[PX +: W]))
                 * ext_c(sub_ext(s3_tri_q[RY +: W], s3_tri_q[PY +: W]))
                 - ext_c(sub_ext(s3_tri_q[QY +: W], s3_tri_q[PY +: W]))
                 * ext_c(sub_ext(s3_tri_q[RX +: W], s3_tri_q[PX +: W]));
        s4_flip_d = s4_cross[CW-1];
        s4_tri_d  = s3_tri_q;
        if (s4_flip_d) begin
            s4_tri_d = {s3_tri_q[VW +: VW], s3_tri_q[2*VW +: VW], s3_tri_q[0 +: VW]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s4_vld_q  <= 1'b0;
            s4_tri_q  <= '0;
            s4_sel_q  <= '0;
            s4_len_q  <= '0;
            s4_flip_q <= 1'b0;
        end else if (pipe_en) begin
            s4_vld_q  <= s3_vld_q;
            s4_tri_q  <= s4_tri_d;
            s4_sel_q  <= s3_sel_q;
            s4_len_q  <= s3_len_q;
            s4_flip_q <= s4_flip_d;
        end
    end

    assign out_valid = s4_vld_q;
    assign tri_out   = s4_tri_q;
    assign edge_sel  = s4_sel_q;
    assign len_sq    = s4_len_q;
    assign flipped   = s4_flip_q;
`else
    assign out_valid = s3_vld_q;
    assign tri_out   = s3_tri_q;
    assign edge_sel  = s3_sel_q;
    assign len_sq    = s3_len_q;
    assign flipped   = 1'b0;
`endif

    // Whole pipe advances together; a bubble at the output never blocks acceptance
    assign pipe_en  = !out_valid || out_ready;
    assign in_ready = pipe_en;

endmodule

// File: tb/tb_reorient_tri_pipe.sv
`timescale 1ns/1ps
module tb_reorient_tri_pipe;

    localparam int W  = 16;
    localparam int TW = 9 * W;
    localparam int LW = 2 * W + 3;
`ifdef REORIENT_WINDING_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    typedef struct {
        logic [TW-1:0] tri_v;
        logic [1:0]    sel;
        logic [LW-1:0] len;
        logic          flip;
    } exp_t;

    typedef struct {
        logic [TW-1:0] stim;
        exp_t          exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [TW-1:0] tri_in;
    logic          out_valid;
    logic          out_ready;
    logic [TW-1:0] tri_out;
    logic [1:0]    edge_sel;
    logic [LW-1:0] len_sq;
    logic          flipped;

    int   checks = 0;
    int   errors = 0;
    int   n_out  = 0;
    exp_t sb[$];
    exp_t cur_exp;
    bit   stall_prev = 0;
    logic [TW-1:0] hold_tri;
    bit   blk_arm = 0;
    bit   saw_block = 0;

    reorient_tri_pipe #(.COORD_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .tri_in    (tri_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .tri_out   (tri_out),
        .edge_sel  (edge_sel),
        .len_sq    (len_sq),
        .flipped   (flipped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [TW-1:0] mk(input int px, input int py, input int pz,
                                         input int qx, input int qy, input int qz,
                                         input int rx, input int ry, input int rz);
        mk = {W'(px), W'(py), W'(pz), W'(qx), W'(qy), W'(qz), W'(rx), W'(ry), W'(rz)};
    endfunction

    function automatic longint crd(input logic [TW-1:0] t, input int idx);
        logic signed [W-1:0] v;
        v   = t[(8 - idx) * W +: W];
        crd = longint'(v);
    endfunction

    function automatic exp_t model(input logic [TW-1:0] t);
        exp_t   e;
        longint x[3], y[3], d[3];
        int     s, tmp;
        int     o[3];
        for (int v = 0; v < 3; v++) begin
            x[v] = crd(t, 3 * v);
            y[v] = crd(t, 3 * v + 1);
        end
        for (int k = 0; k < 3; k++) begin
            d[k] = (x[k] - x[(k + 1) % 3]) * (x[k] - x[(k + 1) % 3])
                 + (y[k] - y[(k + 1) % 3]) * (y[k] - y[(k + 1) % 3]);
        end
        s = (d[0] > d[1]) ? ((d[0] > d[2]) ? 1 : 3) : ((d[1] > d[2]) ? 2 : 3);
        for (int k = 0; k < 3; k++) o[k] = (s - 1 + k) % 3;
        e.flip = 1'b0;
`ifdef REORIENT_WINDING_EN
        if ((x[o[1]] - x[o[0]]) * (y[o[2]] - y[o[0]])
            - (y[o[1]] - y[o[0]]) * (x[o[2]] - x[o[0]]) < 0) begin
            tmp    = o[0];
            o[0]   = o[1];
            o[1]   = tmp;
            e.flip = 1'b1;
        end
`endif
        e.tri_v = {t[(2 - o[0]) * 3 * W +: 3 * W], t[(2 - o[1]) * 3 * W +: 3 * W],
                   t[(2 - o[2]) * 3 * W +: 3 * W]};
        e.sel   = 2'(s);
        e.len   = LW'(d[s - 1]);
        return e;
    endfunction

    // Scoreboard: pop on output transfer first, then push on input transfer
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            stall_prev = 0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", TW'(out_valid), TW'(1));
                chk("stall_tri_hold", tri_out, hold_tri);
            end
            stall_prev = out_valid && !out_ready;
            hold_tri   = tri_out;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got tri %h with empty expect queue", tri_out);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("tri_out", tri_out, e.tri_v);
                    chk("edge_sel", TW'(edge_sel), TW'(e.sel));
                    chk("len_sq", TW'(len_sq), TW'(e.len));
                    chk("flipped", TW'(flipped), TW'(e.flip));
                    n_out++;
                end
            end
            if (in_valid && in_ready) sb.push_back(cur_exp);
            if (blk_arm && !in_ready) begin
                chk("held_at_block", TW'(sb.size()), TW'(LAT));
                blk_arm   = 0;
                saw_block = 1;
            end
        end
    end

    task automatic apply_one(input vec_t v);
        int cyc;
        tri_in   = v.stim;
        cur_exp  = v.exp;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency", TW'(cyc), TW'(LAT));
    endtask

    task automatic stream(input int n, output int cycles);
        logic [159:0] r;
        bit acc;
        int guard;
        cycles = 0;
        for (int i = 0; i < n; i++) begin
            r        = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            tri_in   = r[TW-1:0];
            cur_exp  = model(r[TW-1:0]);
            in_valid = 1'b1;
            guard    = 0;
            do begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk); #1;
                cycles++;
                guard++;
            end while (!acc && guard < 50);
            if (!acc) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: got no in_ready in %0d cycles, required accept", guard);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int exp_outs, input int base);
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 60) begin
            @(posedge clk); #1;
            guard++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk({name, "_drain_empty"}, TW'(sb.size()), TW'(0));
        chk({name, "_out_count"}, TW'(n_out - base), TW'(exp_outs));
    endtask

    vec_t tab[7];

    initial begin
        int cyc, base;
        int a;
        a = 16383;
        tab[0].stim = mk(0, 0, 0, 3, 0, 0, 0, 4, 0);
        tab[0].exp  = '{tri_v: mk(3, 0, 0, 0, 4, 0, 0, 0, 0), sel: 2'd2, len: LW'(25), flip: 1'b0};
        tab[1].stim = '0;
        tab[1].exp  = '{tri_v: '0, sel: 2'd3, len: LW'(0), flip: 1'b0};
        tab[2].stim = mk(0, 0, 0, 1, 0, 0, 1, 1, 0);
        tab[2].exp  = '{tri_v: mk(1, 1, 0, 0, 0, 0, 1, 0, 0), sel: 2'd3, len: LW'(2), flip: 1'b0};
        tab[3].stim = mk(-a, -a, -a, a, a, a, -a, a, -a);
        tab[3].exp  = '{tri_v: mk(-a, -a, -a, a, a, a, -a, a, -a), sel: 2'd1,
                        len: LW'(64'd2147221512), flip: 1'b0};
        tab[4].stim = mk(-32768, 0, 0, 32767, 0, 0, 0, 0, 0);
        tab[4].exp  = '{tri_v: mk(-32768, 0, 0, 32767, 0, 0, 0, 0, 0), sel: 2'd1,
                        len: LW'(64'd4294836225), flip: 1'b0};
        tab[5].stim = mk(0, 0, 5, 0, 4, 6, 3, 0, 7);
        tab[6].stim = mk(0, 0, 1, 1, 3, 2, 2, 0, 3);
`ifdef REORIENT_WINDING_EN
        tab[5].exp  = '{tri_v: mk(3, 0, 7, 0, 4, 6, 0, 0, 5), sel: 2'd2, len: LW'(25), flip: 1'b1};
        tab[6].exp  = '{tri_v: mk(2, 0, 3, 1, 3, 2, 0, 0, 1), sel: 2'd2, len: LW'(10), flip: 1'b1};
`else
        tab[5].exp  = '{tri_v: mk(0, 4, 6, 3, 0, 7, 0, 0, 5), sel: 2'd2, len: LW'(25), flip: 1'b0};
        tab[6].exp  = '{tri_v: mk(1, 3, 2, 2, 0, 3, 0, 0, 1), sel: 2'd2, len: LW'(10), flip: 1'b0};
`endif

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tri_in    = '0;
        cur_exp   = '{tri_v: '0, sel: 2'd0, len: '0, flip: 1'b0};
        #2;
        chk("rst_out_valid", TW'(out_valid), TW'(0));
        chk("rst_tri_out", tri_out, TW'(0));
        chk("rst_edge_sel", TW'(edge_sel), TW'(0));
        chk("rst_len_sq", TW'(len_sq), TW'(0));
        chk("rst_flipped", TW'(flipped), TW'(0));
        chk("rst_in_ready", TW'(in_ready), TW'(1));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Directed table
        for (int i = 0; i < 7; i++) apply_one(tab[i]);
        repeat (2) @(posedge clk);
        #1;

        // Full rate with concurrent push/pop
        base = n_out;
        stream(8, cyc);
        chk("full_rate_cycles", TW'(cyc), TW'(8));
        drain("full_rate", 8, base);

        // Backpressure: out_ready low for 5 cycles starting at cycle 4
        base      = n_out;
        saw_block = 0;
        blk_arm   = 1;
        fork
            stream(10, cyc);
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        blk_arm = 0;
        chk("in_ready_fell", TW'(saw_block), TW'(1));
        drain("backpressure", 10, base);

        // Random ready
        base = n_out;
        fork
            stream(30, cyc);
            begin
                repeat (80) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        drain("random_ready", 30, base);

        // Reset with triangles in flight
        stream(4, cyc);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", TW'(out_valid), TW'(0));
        chk("midrst_tri_out", tri_out, TW'(0));
        chk("midrst_edge_sel", TW'(edge_sel), TW'(0));
        chk("midrst_len_sq", TW'(len_sq), TW'(0));
        chk("midrst_in_ready", TW'(in_ready), TW'(1));
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_hold_valid", TW'(out_valid), TW'(0));
        rst  = 1'b0;
        base = n_out;
        apply_one(tab[0]);
        drain("post_reset", 1, base);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish before 200000ns");
        $fatal(1, "timeout");
    end

endmodule
